mu0_control: RTL and testbench
==============================

MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 The port Clk, input, 1 bit, SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-002 The port Reset, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-003 The port F, input, 4 bits, SHALL carry the opcode, which is IR[15:12] from the registered IR.
REQ-004 The port N, input, 1 bit, SHALL carry the accumulator negative flag, which is ACC[15].
REQ-005 The port Z, input, 1 bit, SHALL carry the accumulator zero flag.
REQ-006 The port Addr_sel, output, 1 bit, SHALL drive the select of the 12-bit address mux: 0 selects PC, 1 selects IR[11:0].
REQ-007 The port X_sel, output, 1 bit, SHALL select the ALU X operand: 0 selects ACC, 1 selects PC.
REQ-008 The port Y_sel, output, 1 bit, SHALL select the ALU Y operand: 0 selects Din, 1 selects IR[11:0].
REQ-009 The port M, output, 2 bits, SHALL select the ALU operation: 00 passes Y, 01 gives X+Y, 10 gives X+1, 11 gives X-Y.
REQ-010 The ports PC_En, IR_En and Acc_En, outputs, 1 bit each, SHALL be the register load enables.
REQ-011 The ports MEMrq and RnW, outputs, 1 bit each, SHALL be the memory request and the read(1)/write(0) select.
REQ-012 The port Halted, output, 1 bit, SHALL be high while the processor is stopped.
REQ-013 The port InstrCount, output, 16 bits, SHALL give the number of executed instructions.

Function
REQ-014 The FSM SHALL have exactly three states: FETCH, EXECUTE and HALT.
REQ-015 The FSM SHALL move from FETCH to EXECUTE unconditionally.
REQ-016 The FSM SHALL move from EXECUTE to HALT when F is STP (7) or undefined (8-15); otherwise it SHALL return to FETCH.
REQ-017 HALT SHALL be absorbing; only Reset SHALL leave it.
REQ-018 Outputs SHALL be combinational from the state and F. Any output not listed for a state/opcode SHALL be 0, except RnW, which SHALL default to 1.
REQ-019 In FETCH, the block SHALL drive Addr_sel=0, MEMrq=1, RnW=1, IR_En=1, PC_En=1, X_sel=1 and M=10.
REQ-020 In EXECUTE with LDA (0), the block SHALL drive Addr_sel=1, MEMrq=1, RnW=1, Y_sel=0, M=00 and Acc_En=1.
REQ-021 In EXECUTE with STA (1), the block SHALL drive Addr_sel=1, MEMrq=1, RnW=0 and X_sel=0, and Acc_En SHALL be 0.
REQ-022 In EXECUTE with ADD (2) or SUB (3), the block SHALL drive Addr_sel=1, MEMrq=1, RnW=1, X_sel=0, Y_sel=0 and Acc_En=1, with M=01 for ADD and M=11 for SUB.
REQ-023 In EXECUTE with JMP (4), the block SHALL drive Y_sel=1, M=00 and PC_En=1, and SHALL NOT make a memory request.
REQ-024 In EXECUTE with JGE (5), the block SHALL drive the same outputs as JMP, except that PC_En SHALL equal ~N.
REQ-025 In EXECUTE with JNE (6), the block SHALL drive the same outputs as JMP, except that PC_En SHALL equal ~Z.
REQ-026 In EXECUTE with STP or an undefined opcode, all enables and MEMrq SHALL be 0.
REQ-027 In HALT, the block SHALL drive Halted=1, all enables=0 and MEMrq=0, and the outputs SHALL be independent of F, N and Z.
REQ-028 InstrCount SHALL increment by 1 on every rising edge leaving EXECUTE, including STP and undefined opcodes.
REQ-029 InstrCount SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 Every instruction SHALL take exactly 2 cycles: FETCH followed by EXECUTE.

Reset
REQ-031 Reset high SHALL immediately, without waiting for a clock edge, force the state to FETCH and InstrCount to 0.
REQ-032 During reset, the outputs SHALL take their FETCH values and Halted SHALL be 0.
REQ-033 Reset asserted in any state, including mid-EXECUTE or HALT, SHALL abort the current instruction; no partial count SHALL be retained.
REQ-034 The first FETCH SHALL occur on the first rising Clk edge after Reset deasserts.

Structure
REQ-035 The opcode constants (LDA..STP), the ALU M codes and the state encoding SHALL live in the shared package mu0_pkg.
REQ-036 The combinational output decode SHALL be the sub-module mu0_ctrl_decode, with inputs state, F, N and Z and all control outputs as its outputs.
REQ-037 mu0_control SHALL hold only the state register, the next-state logic and InstrCount.

Verification
REQ-038 The bench SHALL check: Reset pulse -> Halted=0, InstrCount=0, and the FETCH vector Addr_sel=0, IR_En=1, PC_En=1, M=10 present before any clock edge.
REQ-039 The bench SHALL check: F=0 over two cycles -> cycle 1 shows the FETCH vector; cycle 2 shows Addr_sel=1, Acc_En=1, M=00; InstrCount becomes 1.
REQ-040 The bench SHALL check: EXECUTE with F=5 -> PC_En=0 when N=1 and PC_En=1 when N=0; EXECUTE with F=6 -> PC_En=0 when Z=1.
REQ-041 The bench SHALL check: EXECUTE with F=1 -> RnW=0, MEMrq=1, Addr_sel=1, Acc_En=0.
REQ-042 The bench SHALL check: EXECUTE with F=7 or F=12 -> Halted=1 from the next edge, holding for 10 cycles under random F/N/Z, with InstrCount frozen.
REQ-043 The bench SHALL check: Reset asserted mid-EXECUTE after 3 instructions -> InstrCount=0 and state FETCH immediately; 65536 instructions from reset -> InstrCount wraps to 0.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared MU0 control definitions: opcodes, ALU function codes and FSM state type.
package mu0_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] ALU_PASS_Y = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_INC    = 2'b10;
    localparam logic [1:0] ALU_SUB    = 2'b11;

    // STP and every opcode above it stop the processor.
    function automatic logic is_halting(input logic [3:0] op);
        return op >= OP_STP;
    endfunction

endpackage

// File: rtl/mu0_control_if.sv
// Control bundle between the MU0 controller (slave) and its datapath (master).
interface mu0_control_if;
    logic [3:0]  F;
    logic        N;
    logic        Z;
    logic        Addr_sel;
    logic        X_sel;
    logic        Y_sel;
    logic [1:0]  M;
    logic        PC_En;
    logic        IR_En;
    logic        Acc_En;
    logic        MEMrq;
    logic        RnW;
    logic        Halted;
    logic [15:0] InstrCount;

    modport master (
        output F, N, Z,
        input  Addr_sel, X_sel, Y_sel, M, PC_En, IR_En, Acc_En, MEMrq, RnW, Halted, InstrCount
    );

    modport slave (
        input  F, N, Z,
        output Addr_sel, X_sel, Y_sel, M, PC_En, IR_En, Acc_En, MEMrq, RnW, Halted, InstrCount
    );
endinterface

// File: rtl/mu0_ctrl_decode.sv
// Combinational MU0 control decode from FSM state, opcode and accumulator flags.
module mu0_ctrl_decode
    import mu0_pkg::*;
(
    input  state_t      state_i,
    input  logic [3:0]  f_i,
    input  logic        n_i,
    input  logic        z_i,
    output logic        addr_sel_o,
    output logic        x_sel_o,
    output logic        y_sel_o,
    output logic [1:0]  m_o,
    output logic        pc_en_o,
    output logic        ir_en_o,
    output logic        acc_en_o,
    output logic        memrq_o,
    output logic        rnw_o,
    output logic        halted_o
);

    always_comb begin
        addr_sel_o = 1'b0;
        x_sel_o    = 1'b0;
        y_sel_o    = 1'b0;
        m_o        = ALU_PASS_Y;
        pc_en_o    = 1'b0;
        ir_en_o    = 1'b0;
        acc_en_o   = 1'b0;
        memrq_o    = 1'b0;
        rnw_o      = 1'b1;
        halted_o   = 1'b0;

        unique case (state_i)
            S_FETCH: begin
                memrq_o = 1'b1;
                ir_en_o = 1'b1;
                pc_en_o = 1'b1;
                x_sel_o = 1'b1;
                m_o     = ALU_INC;
            end
            S_EXECUTE: begin
                case (f_i)
                    OP_LDA: begin
                        addr_sel_o = 1'b1;
                        memrq_o    = 1'b1;
                        acc_en_o   = 1'b1;
                    end
                    OP_STA: begin
                        addr_sel_o = 1'b1;
                        memrq_o    = 1'b1;
                        rnw_o      = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        addr_sel_o = 1'b1;
                        memrq_o    = 1'b1;
                        acc_en_o   = 1'b1;
                        m_o        = (f_i == OP_ADD) ? ALU_ADD : ALU_SUB;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        y_sel_o = 1'b1;
                        pc_en_o = (f_i == OP_JMP) ? 1'b1 :
                                  (f_i == OP_JGE) ? ~n_i : ~z_i;
                    end
                    default: ;
                endcase
            end
            S_HALT: halted_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 controller: FETCH/EXECUTE/HALT sequencer and executed-instruction counter.
module mu0_control
    import mu0_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    mu0_control_if.slave  bus
);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            S_FETCH:   state_d = S_EXECUTE;
            S_EXECUTE: begin
                count_d = count_q + 16'd1;
                state_d = is_halting(bus.F) ? S_HALT : S_FETCH;
            end
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    assign bus.InstrCount = count_q;

    mu0_ctrl_decode u_decode (
        .state_i    (state_q),
        .f_i        (bus.F),
        .n_i        (bus.N),
        .z_i        (bus.Z),
        .addr_sel_o (bus.Addr_sel),
        .x_sel_o    (bus.X_sel),
        .y_sel_o    (bus.Y_sel),
        .m_o        (bus.M),
        .pc_en_o    (bus.PC_En),
        .ir_en_o    (bus.IR_En),
        .acc_en_o   (bus.Acc_En),
        .memrq_o    (bus.MEMrq),
        .rnw_o      (bus.RnW),
        .halted_o   (bus.Halted)
    );

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control against an instruction-level reference model.
module tb_mu0_control;

    logic Clk = 1'b0;
    logic Reset;
    mu0_control_if bus();

    mu0_control dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Model: whether the current instruction is in its second cycle, halted flag, count.
    bit m_exec;
    bit m_halt;
    int unsigned m_count;

    // Packed control vector {Addr_sel,X_sel,Y_sel,M,PC_En,IR_En,Acc_En,MEMrq,RnW,Halted}
    function automatic logic [10:0] exp_vec(input bit halted, input bit exec,
                                            input logic [3:0] f, input logic n, input logic z);
        logic as, xs, ys, pe, ie, ae, mr, rw, h;
        logic [1:0] m;
        as = 0; xs = 0; ys = 0; m = 2'b00; pe = 0; ie = 0; ae = 0; mr = 0; rw = 1; h = 0;
        if (halted) begin
            h = 1;
        end else if (!exec) begin
            ie = 1; pe = 1; xs = 1; m = 2'b10; mr = 1;
        end else if (f <= 4'd3) begin
            as = 1; mr = 1;
            if (f == 4'd1) rw = 0;
            else begin
                ae = 1;
                m  = (f == 4'd0) ? 2'b00 : (f == 4'd2) ? 2'b01 : 2'b11;
            end
        end else if (f <= 4'd6) begin
            ys = 1;
            pe = (f == 4'd4) ? 1'b1 : (f == 4'd5) ? ~n : ~z;
        end
        return {as, xs, ys, m, pe, ie, ae, mr, rw, h};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {bus.Addr_sel, bus.X_sel, bus.Y_sel, bus.M, bus.PC_En, bus.IR_En,
                bus.Acc_En, bus.MEMrq, bus.RnW, bus.Halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ctrl"}, 32'(obs_vec()), 32'(exp_vec(m_halt, m_exec, bus.F, bus.N, bus.Z)));
        chk({tag, "_count"}, 32'(bus.InstrCount), m_count);
    endtask

    task automatic tick();
        if (!m_halt) begin
            if (m_exec) begin
                m_count = (m_count + 1) % 65536;
                if (bus.F >= 4'd7) m_halt = 1;
                m_exec = 0;
            end else begin
                m_exec = 1;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_exec = 0; m_halt = 0; m_count = 0;
    endtask

    // Pulse reset away from the clock edge and release it on a falling edge.
    task automatic do_reset();
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all("reset_imm");
        @(negedge Clk);
        Reset = 1'b0;
        #1;
    endtask

    task automatic run_instr(input logic [3:0] f, input logic n, input logic z, input string tag);
        bus.F = f; bus.N = n; bus.Z = z;
        #1;
        check_all({tag, "_fetch"});
        tick();
        check_all({tag, "_exec"});
        tick();
    endtask

    task automatic check_halt_hold(input string tag);
        int unsigned frozen;
        frozen = m_count;
        for (int i = 0; i < 10; i++) begin
            bus.F = 4'($urandom_range(15));
            bus.N = 1'($urandom_range(1));
            bus.Z = 1'($urandom_range(1));
            #1;
            check_all(tag);
            chk({tag, "_halted"}, 32'(bus.Halted), 32'd1);
            chk({tag, "_frozen"}, 32'(bus.InstrCount), frozen);
            tick();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.F = 4'd0; bus.N = 1'b0; bus.Z = 1'b0;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("rst_halted", 32'(bus.Halted), 32'd0);
        chk("rst_count", 32'(bus.InstrCount), 32'd0);
        chk("rst_addr_sel", 32'(bus.Addr_sel), 32'd0);
        chk("rst_ir_en", 32'(bus.IR_En), 32'd1);
        chk("rst_pc_en", 32'(bus.PC_En), 32'd1);
        chk("rst_m", 32'(bus.M), 32'd2);
        @(negedge Clk);
        Reset = 1'b0;
        #1;

        // LDA over two cycles
        bus.F = 4'd0;
        #1;
        check_all("lda_c1");
        tick();
        chk("lda_addr_sel", 32'(bus.Addr_sel), 32'd1);
        chk("lda_acc_en", 32'(bus.Acc_En), 32'd1);
        chk("lda_m", 32'(bus.M), 32'd0);
        check_all("lda_c2");
        tick();
        chk("lda_count", 32'(bus.InstrCount), 32'd1);

        // Conditional jumps and store
        bus.F = 4'd5; bus.N = 1'b1; #1; tick();
        chk("jge_n1_pc_en", 32'(bus.PC_En), 32'd0); check_all("jge_n1"); tick();
        bus.F = 4'd5; bus.N = 1'b0; #1; tick();
        chk("jge_n0_pc_en", 32'(bus.PC_En), 32'd1); check_all("jge_n0"); tick();
        bus.F = 4'd6; bus.Z = 1'b1; #1; tick();
        chk("jne_z1_pc_en", 32'(bus.PC_En), 32'd0); check_all("jne_z1"); tick();
        run_instr(4'd6, 1'b0, 1'b0, "jne_z0");
        bus.F = 4'd1; #1; tick();
        chk("sta_rnw", 32'(bus.RnW), 32'd0);
        chk("sta_memrq", 32'(bus.MEMrq), 32'd1);
        chk("sta_addr_sel", 32'(bus.Addr_sel), 32'd1);
        chk("sta_acc_en", 32'(bus.Acc_En), 32'd0);
        tick();

        for (int i = 0; i < 200; i++)
            run_instr(4'($urandom_range(6)), 1'($urandom_range(1)), 1'($urandom_range(1)), "rand");

        // STP halts and holds
        run_instr(4'd7, 1'b0, 1'b0, "stp");
        check_halt_hold("halt_stp");

        // Reset mid-EXECUTE after three instructions
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(4'($urandom_range(6)), 1'b0, 1'b0, "pre_abort");
        bus.F = 4'd2; #1; tick();
        check_all("abort_exec");
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("abort_count", 32'(bus.InstrCount), 32'd0);
        chk("abort_ctrl", 32'(obs_vec()), 32'(exp_vec(1'b0, 1'b0, bus.F, bus.N, bus.Z)));
        @(negedge Clk);
        Reset = 1'b0;
        #1;

        // Undefined opcode halts too
        run_instr(4'd12, 1'b1, 1'b1, "undef");
        check_halt_hold("halt_undef");
        do_reset();
        check_all("post_halt_reset");

        // Counter wrap over 65536 instructions
        for (int i = 0; i < 65535; i++) begin
            bus.F = 4'($urandom_range(6));
            @(posedge Clk);
            @(posedge Clk);
            #1;
        end
        m_count = 65535;
        chk("wrap_ffff", 32'(bus.InstrCount), 32'hFFFF);
        run_instr(4'd4, 1'b0, 1'b0, "wrap");
        chk("wrap_zero", 32'(bus.InstrCount), 32'd0);
        check_all("wrap_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
